// File: rtl/raw8_frame_packer.sv
// RAW8 pixel packer: four pixels per 32-bit word, written to the frame RAM port A.
// Optional macro RAW8_PACKER_BYTE_SWAP_EN selects big-endian lane order.
module raw8_frame_packer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              sys_clk_i,
    input  logic              reset_i,
    input  logic              frame_start_i,
    input  logic              frame_end_i,
    input  logic              line_start_i,
    input  logic              pix_valid_i,
    input  logic [7:0]        pix_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              frame_done_o,
    output logic              line_err_o,
    output logic              frame_err_o
);
    localparam int X_W   = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    H_MAX         = X_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0]  V_MAX         = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] WORDS_PER_ROW = ADDR_W'(H_ACTIVE / 4);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        LINE      = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [31:0]       pack_q, pack_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;

    logic              flush_s;
    logic              short_s;
    logic              take_pix_s;
    logic [ROW_W-1:0]  pix_row_s;
    logic [X_W-1:0]    pix_x_s;
    logic [31:0]       pix_base_s;
    logic [31:0]       word_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0] r,
                                                     input logic [X_W-1:0]   xx);
        return (ADDR_W'(r) * WORDS_PER_ROW) + ADDR_W'(xx[X_W-1:2]);
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [1:0] l;
`ifdef RAW8_PACKER_BYTE_SWAP_EN
        l = 2'd3 - lane;
`else
        l = lane;
`endif
        return w | ({24'h000000, b} << {l, 3'b000});
    endfunction

    // Next-state, counters, packing and write generation.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        x_d          = x_q;
        pack_d       = pack_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        flush_s      = 1'b0;
        short_s      = 1'b0;
        take_pix_s   = 1'b0;
        pix_row_s    = row_q;
        pix_x_s      = x_q;
        pix_base_s   = pack_q;
        word_s       = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    state_d     = WAIT_LINE;
                    row_d       = '0;
                    x_d         = '0;
                    pack_d      = 32'h0000_0000;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LINE, LINE: begin
                if (frame_start_i) begin
                    state_d     = WAIT_LINE;
                    row_d       = '0;
                    x_d         = '0;
                    pack_d      = 32'h0000_0000;
                    frame_err_d = 1'b1;
                end else if (frame_end_i) begin
                    flush_s      = (x_q[1:0] != 2'b00);
                    short_s      = (state_q == LINE) && (x_q < H_MAX);
                    frame_err_d  = frame_err_q | short_s | ((row_q + ROW_W'(1)) != V_MAX);
                    line_err_d   = line_err_q | short_s;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    row_d        = '0;
                    x_d          = '0;
                    pack_d       = 32'h0000_0000;
                end else if (line_start_i) begin
                    flush_s    = (state_q == LINE) && (x_q[1:0] != 2'b00);
                    line_err_d = line_err_q | ((state_q == LINE) && (x_q < H_MAX));
                    // Row saturates so an over-long frame keeps dropping pixels.
                    row_d      = ((state_q == LINE) && (row_q != V_MAX)) ? row_q + ROW_W'(1) : row_q;
                    x_d        = '0;
                    pack_d     = 32'h0000_0000;
                    state_d    = LINE;
                    take_pix_s = pix_valid_i;
                    pix_row_s  = row_d;
                    pix_x_s    = '0;
                    pix_base_s = 32'h0000_0000;
                end else begin
                    take_pix_s = pix_valid_i && (state_q == LINE);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = word_addr(row_q, x_q);
            wr_data_d = pack_q;
        end else begin
            wr_en_d = 1'b0;
        end

        // A flush never coincides with a completed word: the new line's pixel lands in lane 0.
        if (take_pix_s) begin
            frame_err_d = frame_err_d | (pix_row_s >= V_MAX);
            line_err_d  = line_err_d | (pix_x_s == H_MAX);
            if ((pix_row_s < V_MAX) && (pix_x_s < H_MAX)) begin
                word_s = insert_byte(pix_base_s, pix_x_s[1:0], pix_data_i);
                x_d    = pix_x_s + X_W'(1);
                if (pix_x_s[1:0] == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = word_addr(pix_row_s, pix_x_s);
                    wr_data_d = word_s;
                    pack_d    = 32'h0000_0000;
                end else begin
                    pack_d = word_s;
                end
            end else begin
                word_s = pix_base_s;
            end
        end else begin
            word_s = 32'h0000_0000;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            x_q          <= '0;
            pack_q       <= 32'h0000_0000;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'h0000_0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            x_q          <= x_d;
            pack_q       <= pack_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = frame_done_q;
    assign line_err_o   = line_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_raw8_frame_packer.sv
// Scoreboard bench for raw8_frame_packer on a reduced 16x4 frame.
module tb_raw8_frame_packer;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fs = 1'b0, fe = 1'b0, ls = 1'b0, pv = 1'b0;
    logic [7:0]    pd = 8'h00;
    logic          wr_en, frame_done, line_err, frame_err;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    raw8_frame_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .sys_clk_i    (clk),
        .reset_i      (reset),
        .frame_start_i(fs),
        .frame_end_i  (fe),
        .line_start_i (ls),
        .pix_valid_i  (pv),
        .pix_data_i   (pd),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .frame_done_o (frame_done),
        .line_err_o   (line_err),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
`ifdef RAW8_PACKER_BYTE_SWAP_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // Advance one clock, then retire any write against the scoreboard.
    task automatic tick();
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            checks++;
            wr_cnt++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%08h required no write", wr_addr, wr_data);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (wr_addr !== ea || wr_data !== ed) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%08h required addr=%0d data=%08h",
                             wr_addr, wr_data, ea, ed);
                end
            end
        end
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic drive(input logic fs_v, fe_v, ls_v, pv_v, input logic [7:0] d);
        fs = fs_v; fe = fe_v; ls = ls_v; pv = pv_v; pd = d;
        tick();
        fs = 1'b0; fe = 1'b0; ls = 1'b0; pv = 1'b0; pd = 8'h00;
    endtask

    task automatic push(input int a, input logic [31:0] d);
        exp_addr_q.push_back(AW'(a));
        exp_data_q.push_back(d);
    endtask

    // Pixel data is {row, x}; expected words are queued as each fourth pixel goes out.
    task automatic send_line(input int r, input int n);
        logic [7:0] d;
        for (int x = 0; x < n; x++) begin
            d = 8'(((r & 15) << 4) | (x & 15));
            if ((x % 4 == 3) && (x < H))
                push(r * (H / 4) + x / 4, pack4(d - 8'd3, d - 8'd2, d - 8'd1, d));
            drive(1'b0, 1'b0, 1'b0, 1'b1, d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b required 0", wr_en); end
        checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got %0d required 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %08h required 0", wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b required 0", frame_done); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL reset_line_err got %b required 0", line_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b required 0", frame_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < V; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            send_line(r, H);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL nom_frame_done got %b required 1", frame_done); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL nom_line_err got %b required 0", line_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nom_frame_err got %b required 0", frame_err); end
        checks++; if (wr_cnt - w0 != H * V / 4) begin errors++; $display("FAIL nom_writes got %0d required %0d", wr_cnt - w0, H * V / 4); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL nom_done_pulse got %b required 0", frame_done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nom_done_count got %0d required 1", done_cnt - d0); end
        checks++; if (wr_addr !== 4'd15 || wr_data !== pack4(8'h3C, 8'h3D, 8'h3E, 8'h3F)) begin
            errors++; $display("FAIL nom_hold got addr=%0d data=%08h required addr=15 data=%08h",
                               wr_addr, wr_data, pack4(8'h3C, 8'h3D, 8'h3E, 8'h3F));
        end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL nom_pending got %0d required 0", exp_addr_q.size()); end
    endtask

    task automatic test_short_line();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(0, pack4(8'h11, 8'h12, 8'h13, 8'h14));
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h11 + i));
        push(1, pack4(8'h15, 8'h16, 8'h00, 8'h00));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL short_line_err got %b required 1", line_err); end
        push(H / 4, pack4(8'h21, 8'h22, 8'h23, 8'h24));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h21 + i));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err got %b required 1", frame_err); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL short_pending got %0d required 0", exp_addr_q.size()); end
    endtask

    task automatic test_long_line();
        int w0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (line_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL long_flags_cleared got line=%b frame=%b required 0 0", line_err, frame_err);
        end
        w0 = wr_cnt;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(0, H + 2);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL long_line_err got %b required 1", line_err); end
        checks++; if (wr_cnt - w0 != H / 4) begin errors++; $display("FAIL long_writes got %0d required %0d", wr_cnt - w0, H / 4); end
        for (int r = 1; r < V; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            send_line(r, H);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL long_frame_err got %b required 0", frame_err); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL long_pending got %0d required 0", exp_addr_q.size()); end
    endtask

    task automatic test_restart();
        int w0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            send_line(r, H);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(3, 2);
        w0 = wr_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL restart_frame_err got %b required 1", frame_err); end
        tick();
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL restart_no_flush got %0d writes required 0", wr_cnt - w0); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(0, 4);
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL restart_pending got %0d required 0", exp_addr_q.size()); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(0, 5);
        push(1, pack4(8'h04, 8'h00, 8'h00, 8'h00));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL simul_line_err got %b required 1", line_err); end
        push(H / 4, pack4(8'hAA, 8'hB1, 8'hB2, 8'hB3));
        for (int i = 1; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'hB0 + i));
        push(H / 4 + 1, pack4(8'hC0, 8'h00, 8'h00, 8'h00));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        checks++; if (wr_en !== 1'b1 || frame_done !== 1'b1) begin
            errors++; $display("FAIL simul_end_flush got wr_en=%b done=%b required 1 1", wr_en, frame_done);
        end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL simul_pending got %0d required 0", exp_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(0, 2);
        push(0, pack4(8'h00, 8'h01, 8'h00, 8'h00));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_line(1, 3);
        w0 = wr_cnt;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h13);
        reset = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got %b required 0", wr_en); end
        checks++; if (wr_addr !== 4'd0 || wr_data !== 32'h0) begin
            errors++; $display("FAIL rstmid_wr_bus got addr=%0d data=%08h required 0 0", wr_addr, wr_data);
        end
        checks++; if (line_err !== 1'b0 || frame_err !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got line=%b frame=%b done=%b required 0 0 0", line_err, frame_err, frame_done);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h50 + i));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL rstmid_idle_writes got %0d required 0", wr_cnt - w0); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL rstmid_pending got %0d required 0", exp_addr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_long_line();
        test_restart();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raw8_frame_packer.md
# raw8_frame_packer

Write-side stage between the MIPI receiver and the dual-clock frame RAM. Takes the RAW8 pixel byte stream with frame and line markers, packs four pixels per 32-bit word, and generates the RAM port-A write enable, word address and data. Row layout matches the HDMI-side reader: byte `addr[1:0]` of pixel address `addr` lives in word `addr[18:2]`.

## Interface
- `H_ACTIVE`, 640, pixels per line; must be a multiple of 4.
- `V_ACTIVE`, 480, lines per frame.
- `ADDR_W`, 17, word address width; must satisfy `2^ADDR_W >= H_ACTIVE*V_ACTIVE/4`.
- `sys_clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse, start of frame.
- `frame_end`  in  1  one-cycle pulse, end of frame.
- `line_start`  in  1  one-cycle pulse, start of each line, including the first.
- `pix_valid`  in  1  `pix_data` valid this cycle.
- `pix_data`  in  8  RAW8 pixel.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM word address.
- `wr_data`  out  32  packed word.
- `frame_done`  out  1  one-cycle pulse, frame closed.
- `line_err`  out  1  sticky: a short or long line was seen this frame.
- `frame_err`  out  1  sticky: wrong line count, or a restart mid-frame.

## Operation
- States:
  - IDLE: ignores pixels and `line_start`; `frame_start` -> WAIT_LINE.
  - WAIT_LINE: `line_start` -> LINE.
  - LINE: accepts pixels.
- Counters:
  - `row`, 0..V_ACTIVE: incremented on every `line_start` after the first of the frame.
  - `x`, 0..H_ACTIVE: pixels accepted in the current line.
- Pixel acceptance:
  - In LINE, a pixel is accepted when `pix_valid` is high and `x < H_ACTIVE` and `row < V_ACTIVE`.
  - With `x == H_ACTIVE`, the pixel is dropped and `line_err` is set.
  - With `row >= V_ACTIVE`, the pixel is dropped and `frame_err` is set.
- Packing:
  - Pixel `x` goes to byte lane `x[1:0]`: lane 0 = `[7:0]`, lane 3 = `[31:24]`.
  - When lane 3 is filled, the word is written at `row*(H_ACTIVE/4) + x[..:2]`.
- `line_start` while in LINE:
  - If `x < H_ACTIVE`, set `line_err`.
  - If `x[1:0] != 0`, flush the partial word with unfilled lanes as 0x00, at the address that word would have had.
  - Then `row++` and `x = 0`.
- `frame_end` in WAIT_LINE or LINE:
  - Flush any partial word under the same rule.
  - Set `frame_err` if `row+1 != V_ACTIVE` or the last line is short; a short last line also sets `line_err`.
  - Pulse `frame_done` and go to IDLE.
- `frame_start` outside IDLE (restart):
  - Set `frame_err` and discard the partial word without writing it.
  - Reset `row` and `x`, go to WAIT_LINE, and keep the sticky flags.
- `frame_start` from IDLE: clears `line_err` and `frame_err`.
- Simultaneous events, in priority order:
  1. `frame_start`.
  2. `frame_end`.
  3. `line_start`.
  4. pixel.
  - `line_start` together with `pix_valid`: the old line is closed (flush if needed), then the pixel is accepted as `x=0` of the new line.
  - `frame_end` together with `pix_valid`: the pixel is dropped.

## Timing
- Values after reset:
  - State IDLE.
  - `wr_en`, `frame_done`, `line_err`, `frame_err` = 0.
  - `wr_addr`, `wr_data` = 0.
  - `row`, `x` and the pack register = 0.
- All outputs are registered.
- Write timing:
  - `wr_en` is high for exactly one cycle, one cycle after the 4th pixel is accepted, or one cycle after the closing `line_start`/`frame_end` when flushing.
  - `wr_addr` and `wr_data` are valid while `wr_en` is high and hold their value otherwise.
- `frame_done` is high for one cycle, one cycle after `frame_end`, concurrent with the final flush write if there is one.
- Throughput:
  - One pixel per cycle sustained.
  - At most one write per cycle, guaranteed because a flush only occurs when no word completed in the same cycle.
- Reset mid-frame: the next cycle is IDLE with no write issued; pending partial data is lost.

## Configuration
- `RAW8_PACKER_BYTE_SWAP_EN`
  - Defined: big-endian packing; pixel `x[1:0]==0` goes to `[31:24]` and lane 3 to `[7:0]`. Flush padding stays in the unfilled lanes.
  - Undefined (default): little-endian packing as described under Operation.

## Test plan
- Nominal frame, 640x480:
  - Send `frame_start`, 480 lines of 640 pixels `pix_data = x[7:0]`, then `frame_end`.
  - Expect 76800 writes at addresses 0..76799; word 0 = 0x03020100, word 159 = 0x7F7E7D7C.
  - Expect one `frame_done` and both error flags 0.
- Short line:
  - Line 0 has 6 pixels 0x11..0x16, then `line_start`.
  - Expect writes addr 0 = 0x14131211 and addr 1 = 0x00001615; `line_err` = 1; the next line writes from addr 160.
- Long line:
  - Line 0 has 642 pixels.
  - Expect 160 writes, extra pixels dropped, `line_err` = 1.
- Restart mid-frame:
  - After 3 lines plus 2 pixels, assert `frame_start`.
  - Expect no flush write, `frame_err` = 1, and the next line writing from addr 0.
- Simultaneous events:
  - `line_start` together with `pix_valid` (data 0xAA) after 5 pixels.
  - Expect a flush of the 1-pixel partial word; the new line's word 0 has 0xAA in `[7:0]`.
- Reset and byte swap:
  - Assert `reset` mid-line: all outputs 0 the next cycle, no `wr_en`.
  - With `RAW8_PACKER_BYTE_SWAP_EN` defined, the nominal frame gives word 0 = 0x00010203.
